// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader: fetches NUM_PADS pad configuration words (highest index first)
// and shifts each one MSB first into the GPIO control-block serial chain, then
// pulses serial_load to latch the whole chain.
//
// Optional feature: define GPIO_CFG_TIMEOUT_EN to build a FETCH watchdog. When
// TIMEOUT cycles pass without cfg_valid, the sequence aborts: error is set, LOAD
// is skipped and done still pulses. Without the macro, FETCH waits forever and
// error is tied to 0.
//
// Ports:
//   clock, resetb          block clock, asynchronous active-low reset
//   start                  one-cycle request to load the whole chain (IDLE only)
//   busy, done, error      sequence in progress / end pulse / sticky abort flag
//   cfg_req, cfg_idx       word fetch request and index of the requested word
//   cfg_valid, cfg_word    fetch acknowledge and the word, valid in that cycle
//   serial_clock/_load/_resetn/_data   GPIO serial chain outputs
module gpio_cfg_loader #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 2,   // serial_clock half-period, 1..255
  parameter int unsigned TIMEOUT  = 255,
  localparam int unsigned IdxW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cfg_req,
  output logic [IdxW-1:0]     cfg_idx,
  input  logic                cfg_valid,
  input  logic [CFG_BITS-1:0] cfg_word,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_resetn,
  output logic                serial_data
);

  localparam int unsigned     BitW    = $clog2(CFG_BITS + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(CFG_BITS - 1);
  localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PADS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StLoad, StDone} state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] shift_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [7:0]          div_cnt_q;
  logic                load_half_q;  // LOAD is two divider periods long
  logic                div_wrap;

`ifdef GPIO_CFG_TIMEOUT_EN
  localparam int unsigned      WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [WaitW-1:0] wait_cnt_q;
  logic             error_q;

  assign error = error_q;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign error          = 1'b0;
`endif

  assign div_wrap    = (div_cnt_q == DivLast);
  // The data bit is the MSB of the shift register, so it is a flop output and
  // only moves on the falling serial_clock transition.
  assign serial_data = shift_q[CFG_BITS-1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_req       <= 1'b0;
      cfg_idx       <= '0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      load_half_q   <= 1'b0;
`ifdef GPIO_CFG_TIMEOUT_EN
      wait_cnt_q    <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      serial_resetn <= 1'b1;
      done          <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            busy    <= 1'b1;
            cfg_req <= 1'b1;
            cfg_idx <= LastIdx;
`ifdef GPIO_CFG_TIMEOUT_EN
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
`endif
          end
        end

        StFetch: begin
          if (cfg_valid) begin
            state_q   <= StShift;
            cfg_req   <= 1'b0;
            shift_q   <= cfg_word;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
`ifdef GPIO_CFG_TIMEOUT_EN
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitLast) begin
            state_q <= StDone;
            cfg_req <= 1'b0;
            error_q <= 1'b1;
            done    <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
`endif
          end
        end

        StShift: begin
          if (div_wrap) begin
            div_cnt_q <= '0;
            if (!serial_clock) begin
              serial_clock <= 1'b1;
            end else begin
              // End of a bit: clock falls, next bit (if any) is presented.
              serial_clock <= 1'b0;
              if (bit_cnt_q == LastBit) begin
                if (cfg_idx != '0) begin
                  cfg_idx <= cfg_idx - IdxW'(1);
                  state_q <= StFetch;
                  cfg_req <= 1'b1;
                end else begin
                  state_q     <= StLoad;
                  serial_load <= 1'b1;
                  load_half_q <= 1'b0;
                  shift_q     <= '0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BitW'(1);
                shift_q   <= shift_q << 1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        StLoad: begin
          if (div_wrap) begin
            div_cnt_q <= '0;
            if (load_half_q) begin
              serial_load <= 1'b0;
              state_q     <= StDone;
              done        <= 1'b1;
            end else begin
              load_half_q <= 1'b1;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
